block_stager: RTL and testbench

//  N-way block buffer between a byte producer (uart) and a block consumer (spi WRITE sequencer).

---
 rtl/block_stager_pkg.sv | 27 ++
 rtl/block_stager_if.sv | 37 +++
 rtl/block_stager_ram.sv | 23 ++
 rtl/block_stager.sv | 196 +++++++++++++++++++
 tb/tb_block_stager.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_stager_pkg.sv
// block_stager shared types: bank states, flush FSM states, block tags.
// Optional build macro: BLOCK_STAGER_PAD_EN (all-ones padding of partial blocks).
package stager_pkg;

  localparam int STAGER_ADDR_W = 24;
  localparam int TAG_AW = 32;
  localparam int TAG_LW = 17;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    READY,
    DRAINING
  } bank_state_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PAD,
    ST_END
  } flush_st_t;

  typedef struct packed {
    logic [TAG_AW-1:0] addr;
    logic [TAG_LW-1:0] len;
  } blk_tag_t;

endpackage

// File: rtl/block_stager_if.sv
// block_stager bus: producer word stream, head-block handshake, bank read port.
// Optional build macro: BLOCK_STAGER_PAD_EN (no effect on this interface).
interface block_stager_if #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 24,
  parameter int BLOCK_SIZE = 256
);
  localparam int BB = $clog2(BLOCK_SIZE);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              blk_valid;
  logic              blk_ready;
  logic [ADDR_W-1:0] blk_addr;
  logic [BB:0]       blk_len;
  logic [BB-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              blk_release;
  logic              stream_done;

  modport master (
    output in_data, in_valid, flush,
    output blk_ready, rd_addr, blk_release,
    input  in_ready, blk_valid, blk_addr,
    input  blk_len, rd_data, stream_done
  );

  modport slave (
    input  in_data, in_valid, flush,
    input  blk_ready, rd_addr, blk_release,
    output in_ready, blk_valid, blk_addr,
    output blk_len, rd_data, stream_done
  );

endinterface

// File: rtl/block_stager_ram.sv
// Single bank storage: synchronous write, asynchronous read.
// Optional build macro: BLOCK_STAGER_PAD_EN (no effect on this module).
module ram #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/block_stager.sv
// N-bank ring staging producer words into tagged flash blocks.
// BLOCK_STAGER_PAD_EN: pad a flushed partial block with all-ones to full size.
module block_stager
  import stager_pkg::*;
#(
  parameter int NUM_BUFS   = 2,
  parameter int BLOCK_SIZE = 256,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = STAGER_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic           clk,
  input logic           n_rst,
  block_stager_if.slave bus
);

  localparam int BB = $clog2(BLOCK_SIZE);
  localparam int PW = $clog2(NUM_BUFS);
  localparam logic [BB-1:0] LAST = BB'(BLOCK_SIZE - 1);
  localparam logic [BB:0]   FULL = (BB+1)'(BLOCK_SIZE);

  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t inc(ptr_t p);
    return (int'(p) == NUM_BUFS - 1) ? '0 : p + ptr_t'(1);
  endfunction

  bank_state_t       bank_q [NUM_BUFS];
  bank_state_t       bank_d [NUM_BUFS];
  blk_tag_t          tag_q  [NUM_BUFS];
  blk_tag_t          tag_d  [NUM_BUFS];
  ptr_t              wr_q, wr_d;
  ptr_t              rd_q, rd_d;
  ptr_t              dr_q, dr_d;
  logic [BB-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;
  flush_st_t         st_q, st_d;
  logic [DATA_W-1:0] rdat_q;

  logic              accept;
  logic              draining;
  logic              rel_ok;
  logic              head_v;
  logic              take;
  logic              we;
  logic              commit;
  logic              all_free;
  logic [BB:0]       cnt;
  logic [BB:0]       clen;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata [NUM_BUFS];

  for (genvar g = 0; g < NUM_BUFS; g++) begin : g_bank
    ram #(
      .ADDR_SIZE (BB),
      .DATA_SIZE (DATA_W)
    ) u_ram (
      .clk   (clk),
      .we    (we && (wr_q == ptr_t'(g))),
      .waddr (idx_q),
      .wdata (wdata),
      .raddr (bus.rd_addr),
      .rdata (rdata[g])
    );
  end

  always_comb begin
    bank_d = bank_q;
    tag_d  = tag_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    dr_d   = dr_q;
    idx_d  = idx_q;
    nxt_d  = nxt_q;
    st_d   = st_q;
    we     = 1'b0;
    wdata  = bus.in_data;
    commit = 1'b0;
    clen   = '0;

    accept   = bus.in_valid && rdy_q;
    draining = bank_q[dr_q] == DRAINING;
    rel_ok   = bus.blk_release && draining;
    head_v   = (bank_q[rd_q] == READY) && (!draining || rel_ok);
    take     = head_v && bus.blk_ready;
    cnt      = {1'b0, idx_q} + (BB+1)'(accept);

    // release is applied before the head may start draining
    if (rel_ok) bank_d[dr_q] = FREE;
    if (take) begin
      bank_d[rd_q] = DRAINING;
      dr_d = rd_q;
      rd_d = inc(rd_q);
    end

    unique case (st_q)
      ST_RUN: begin
        if (accept) begin
          we    = 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            commit = 1'b1;
            clen   = FULL;
          end
        end
        if (bus.flush) begin
          st_d = ST_END;
          if (!commit) begin
            if (cnt != '0) begin
`ifdef BLOCK_STAGER_PAD_EN
              st_d  = ST_PAD;
`else
              commit = 1'b1;
              clen   = cnt;
`endif
            end else if (bank_q[wr_q] == FILLING) begin
              bank_d[wr_q] = FREE;
            end
          end
        end
      end
      ST_PAD: begin
        we    = 1'b1;
        wdata = '1;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          commit = 1'b1;
          clen   = FULL;
          st_d   = ST_END;
        end
      end
      default: ;
    endcase

    if (commit) begin
      bank_d[wr_q]     = READY;
      tag_d[wr_q].addr = TAG_AW'(nxt_q);
      tag_d[wr_q].len  = TAG_LW'(clen);
      nxt_d = nxt_q + ADDR_W'(BLOCK_SIZE);
      wr_d  = inc(wr_q);
      idx_d = '0;
    end

    // a bank freed this cycle is only reused on the following cycle
    if (st_d == ST_RUN && bank_q[wr_d] == FREE)
      bank_d[wr_d] = FILLING;

    rdy_d = (st_d == ST_RUN) && (bank_d[wr_d] == FILLING);

    all_free = 1'b1;
    for (int i = 0; i < NUM_BUFS; i++)
      if (bank_q[i] != FREE) all_free = 1'b0;
    done_d = done_q || (st_q != ST_RUN && all_free);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        bank_q[i]     <= (i == 0) ? FILLING : FREE;
        tag_q[i].addr <= TAG_AW'(BASE_ADDR);
        tag_q[i].len  <= '0;
      end
      wr_q   <= '0;
      rd_q   <= '0;
      dr_q   <= '0;
      idx_q  <= '0;
      nxt_q  <= BASE_ADDR;
      rdy_q  <= 1'b1;
      done_q <= 1'b0;
      st_q   <= ST_RUN;
      rdat_q <= '0;
    end else begin
      bank_q <= bank_d;
      tag_q  <= tag_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      dr_q   <= dr_d;
      idx_q  <= idx_d;
      nxt_q  <= nxt_d;
      rdy_q  <= rdy_d;
      done_q <= done_d;
      st_q   <= st_d;
      rdat_q <= rdata[dr_q];
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.blk_valid   = head_v;
  assign bus.blk_addr    = tag_q[rd_q].addr[ADDR_W-1:0];
  assign bus.blk_len     = tag_q[rd_q].len[BB:0];
  assign bus.rd_data     = rdat_q;
  assign bus.stream_done = done_q;

endmodule

// File: tb/tb_block_stager.sv
// Randomised directed bench for block_stager against a block-level model.
// Optional build macro: BLOCK_STAGER_PAD_EN (model pads partial blocks).
module tb_block_stager;

  localparam int NB = 3;
  localparam int BS = 16;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int BB = $clog2(BS);
  localparam logic [AW-1:0] BASE = 8'hE0;
`ifdef BLOCK_STAGER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  block_stager_if #(
    .DATA_W (DW), .ADDR_W (AW), .BLOCK_SIZE (BS)
  ) bus ();

  block_stager #(
    .NUM_BUFS (NB), .BLOCK_SIZE (BS), .DATA_W (DW),
    .ADDR_W (AW), .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int words[$];
  int q_addr[$];
  int q_len[$];
  int cur = 0;
  int k = 0;
  bit flushed = 0;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic void m_commit(int len);
    q_addr.push_back((int'(BASE) + k * BS) % (1 << AW));
    q_len.push_back(len);
    k++;
    cur = 0;
  endfunction

  function automatic void m_accept(int d);
    words.push_back(d);
    cur++;
    if (cur == BS) m_commit(BS);
  endfunction

  function automatic void m_flush();
    if (flushed) return;
    flushed = 1;
    if (cur == 0) return;
    if (PAD) begin
      for (int i = cur; i < BS; i++)
        words.push_back((1 << DW) - 1);
      m_commit(BS);
    end else begin
      m_commit(cur);
    end
  endfunction

  function automatic void m_reset();
    words.delete();
    q_addr.delete();
    q_len.delete();
    cur = 0;
    k = 0;
    flushed = 0;
  endfunction

  task automatic idle_inputs();
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.blk_ready = 1'b0;
    bus.rd_addr = '0;
    bus.blk_release = 1'b0;
  endtask

  task automatic reset_dut(bit chk);
    @(negedge clk);
    n_rst = 1'b0;
    idle_inputs();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    if (chk) begin
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_blk_valid", bus.blk_valid, 0);
      check("rst_blk_addr", bus.blk_addr, BASE);
      check("rst_blk_len", bus.blk_len, 0);
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_done", bus.stream_done, 0);
    end
    n_rst = 1'b1;
  endtask

  task automatic send(int n, bit fl);
    int sent = 0;
    int guard = 0;
    int d;
    while (sent < n && guard < 400) begin
      @(negedge clk);
      guard++;
      bus.flush = 1'b0;
      d = int'($urandom_range(0, 255));
      bus.in_data = DW'(d);
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else if (bus.in_ready) begin
        bus.in_valid = 1'b1;
        m_accept(d);
        sent++;
        if (fl && sent == n) begin
          bus.flush = 1'b1;
          m_flush();
        end
      end else begin
        bus.in_valid = 1'b1;
      end
    end
    check("send_count", sent, n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic consume(bit rel);
    int g = 0;
    int a;
    int l;
    while (!bus.blk_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("blk_valid_wait", bus.blk_valid, 1);
    if (!bus.blk_valid || q_addr.size() == 0) return;
    a = q_addr.pop_front();
    l = q_len.pop_front();
    check("blk_addr", bus.blk_addr, a);
    check("blk_len", bus.blk_len, l);
    bus.blk_ready = 1'b1;
    @(negedge clk);
    bus.blk_ready = 1'b0;
    check("valid_while_drain", bus.blk_valid, 0);
    for (int i = 0; i < l; i++) begin
      bus.rd_addr = BB'(i);
      @(negedge clk);
      check("rd_data", bus.rd_data, words.pop_front());
    end
    if (rel) begin
      bus.blk_release = 1'b1;
      @(negedge clk);
      bus.blk_release = 1'b0;
    end
  endtask

  task automatic wait_done();
    int g = 0;
    while (!bus.stream_done && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("stream_done", bus.stream_done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset_dut(1);

    // two full blocks, consumed in order
    send(2 * BS, 0);
    consume(1);
    consume(1);
    check("no_extra_blk", bus.blk_valid, 0);

    // fill every bank without releasing
    send(NB * BS, 0);
    check("full_in_ready", bus.in_ready, 0);
    consume(0);
    check("drain_in_ready", bus.in_ready, 0);
    bus.blk_release = 1'b1;
    @(negedge clk);
    bus.blk_release = 1'b0;
    check("bubble_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("refill_in_ready", bus.in_ready, 1);
    send(BS, 0);
    consume(1);
    consume(1);
    consume(1);

    // partial block then flush
    reset_dut(0);
    send(5, 1);
    consume(1);
    wait_done();
    check("post_flush_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (4) @(negedge clk);
    check("post_flush_valid", bus.blk_valid, 0);
    check("post_flush_ready2", bus.in_ready, 0);
    bus.in_valid = 1'b0;

    // flush together with the last word of a full block
    reset_dut(0);
    send(BS, 1);
    consume(1);
    repeat (3) @(negedge clk);
    check("no_empty_blk", bus.blk_valid, 0);
    wait_done();

    // flush with nothing buffered
    reset_dut(0);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    wait_done();
    check("empty_flush_valid", bus.blk_valid, 0);

    // reset while a block is pending and another filling
    reset_dut(0);
    send(BS + 5, 0);
    check("pending_valid", bus.blk_valid, 1);
    reset_dut(1);
    send(BS, 0);
    consume(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
